// File: rtl/fifo_uart_drain_pkg.sv
// Shared definitions for the FIFO-to-UART drain: line states and baud divisor helper.
package fifo_uart_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned BIT_IDX_W = 3;
  localparam int unsigned CNT_W_FRM = 16;

  // Truncating divide: one UART bit lasts this many clk cycles.
  function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/fifo_uart_drain_baud_tick.sv
// Free-running bit-period counter; tick_c marks the last cycle of each bit, clr restarts the period.
module fifo_uart_drain_baud_tick #(
  parameter int unsigned DIV = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_c = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick_c) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops one FIFO word per frame and shifts it out as 8N1 UART, back-to-back while words and enable allow.
module fifo_uart_drain
  import fifo_uart_drain_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 12_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);

  if (DATA_WIDTH != 8) begin : g_width_check
    $error("fifo_uart_drain: DATA_WIDTH must be 8");
  end
  if (BAUD_DIV < 1) begin : g_baud_check
    $error("fifo_uart_drain: CLK_FREQ must be at least BAUD");
  end

  uart_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [BIT_IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic                    tx_q, tx_d;
  logic [CNT_W_FRM-1:0]    frame_cnt_q, frame_cnt_d;
  logic                    tick_c;
  logic                    launch_c;

  fifo_uart_drain_baud_tick #(
    .DIV (BAUD_DIV)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr    (launch_c),
    .tick_c (tick_c)
  );

  // A new frame may start from idle, or directly on the stop bit's final cycle.
  assign launch_c = rst && en && !fifo_empty &&
                    ((state_q == ST_IDLE) || ((state_q == ST_STOP) && tick_c));

  assign fifo_rd_en = launch_c;
  assign tx         = tx_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_cnt  = frame_cnt_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    tx_d        = tx_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
      end
      ST_START: begin
        if (tick_c) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          if (bit_idx_q == BIT_IDX_W'(DATA_WIDTH - 1)) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick_c) begin
          state_d     = ST_IDLE;
          frame_cnt_d = frame_cnt_q + CNT_W_FRM'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // Pop and capture on the same edge; the start bit goes out immediately.
    if (launch_c) begin
      state_d   = ST_START;
      shift_d   = fifo_data;
      bit_idx_d = '0;
      tx_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      tx_q        <= 1'b1;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: queue-backed FIFO, per-cycle line model, scenario table and random traffic.
module tb_fifo_uart_drain;

  localparam int unsigned BD    = 104;
  localparam int unsigned FRAME = 10 * BD;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic        tx;
  logic        busy;
  logic [15:0] frame_cnt;

  fifo_uart_drain #(
    .CLK_FREQ   (12_000_000),
    .BAUD       (115200),
    .DATA_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            en;
    int              nwords;
    logic [2:0][7:0] w;
    int              drop_en_at;
    int              cycles;
    int              exp_pops;
    logic [15:0]     exp_cnt;
  } vec_t;

  vec_t        tbl[4];
  logic [7:0]  q[$];
  int          act_pops[$];
  int          cyc;
  bit          fr_act;
  int          fr_start;
  logic [7:0]  fr_data;
  logic [15:0] exp_cnt;
  int          vectors;
  int          miscompares;

  function automatic vec_t mk(input string name, input logic e, input int n, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] c, input int drop,
                              input int cycles, input int pops, input logic [15:0] cnt);
    vec_t v;
    v.name = name; v.en = e; v.nwords = n;
    v.w[0] = a; v.w[1] = b; v.w[2] = c;
    v.drop_en_at = drop; v.cycles = cycles; v.exp_pops = pops; v.exp_cnt = cnt;
    return v;
  endfunction

  // Line level implied by the frame in flight: start, LSB-first data, stop.
  function automatic logic model_tx();
    int k;
    if (!fr_act) return 1'b1;
    k = (cyc - fr_start) / BD;
    if (k == 0) return 1'b0;
    if (k <= 8) return fr_data[k-1];
    return 1'b1;
  endfunction

  task automatic check1(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() != 0) ? q[0] : 8'($urandom);
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic exp_rd;
    @(negedge clk);
    exp_rd = rst && en && (q.size() != 0) &&
             (!fr_act || ((cyc + 1 - fr_start) == int'(FRAME)));
    check1("rd_en", 16'(fifo_rd_en), 16'(exp_rd));
    check1("tx", 16'(tx), 16'(model_tx()));
    check1("busy", 16'(busy), 16'(fr_act));
    check1("frame_cnt", frame_cnt, exp_cnt);
    if (fifo_rd_en === 1'b1) act_pops.push_back(cyc + 1);
    @(posedge clk);
    cyc++;
    if (fr_act && (cyc - fr_start) == int'(FRAME)) begin
      fr_act  = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
    end
    if (exp_rd) begin
      fr_act   = 1'b1;
      fr_start = cyc;
      fr_data  = q.pop_front();
    end
    #1;
    drive_fifo();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    fr_act = 1'b0; fr_start = 0; fr_data = '0; exp_cnt = '0;
    tbl[0] = mk("single_a5", 1'b1, 1, 8'hA5, 8'h00, 8'h00, -1, 1100, 1, 16'd1);
    tbl[1] = mk("three_b2b", 1'b1, 3, 8'h00, 8'hFF, 8'h3C, -1, 3200, 3, 16'd4);
    tbl[2] = mk("en_drop",   1'b1, 3, 8'h55, 8'h11, 8'h22, 450, 1200, 1, 16'd5);
    tbl[3] = mk("empty_idle",1'b1, 0, 8'h00, 8'h00, 8'h00, -1, 5000, 0, 16'd5);

    // Reset held with a word waiting and enable high: line must stay idle.
    rst = 1'b1; en = 1'b1;
    q.push_back(8'h42);
    drive_fifo();
    #1 rst = 1'b0;
    run(5);
    rst = 1'b1;
    act_pops.delete();
    step();
    check1("pop_after_release", 16'(act_pops.size()), 16'd1);
    run(300);

    // Asynchronous reset in the middle of the data bits.
    rst = 1'b0;
    #1;
    check1("async_rst_tx", 16'(tx), 16'd1);
    check1("async_rst_busy", 16'(busy), 16'd0);
    check1("async_rst_cnt", frame_cnt, 16'd0);
    fr_act = 1'b0;
    exp_cnt = '0;
    run(3);
    rst = 1'b1;
    run(20);

    for (int i = 0; i < 4; i++) begin
      act_pops.delete();
      en = tbl[i].en;
      for (int j = 0; j < tbl[i].nwords; j++) q.push_back(tbl[i].w[j]);
      drive_fifo();
      for (int c = 0; c < tbl[i].cycles; c++) begin
        if (c == tbl[i].drop_en_at) en = 1'b0;
        step();
      end
      check1({tbl[i].name, "_pops"}, 16'(act_pops.size()), 16'(tbl[i].exp_pops));
      check1({tbl[i].name, "_cnt"}, frame_cnt, tbl[i].exp_cnt);
      check1({tbl[i].name, "_tx_idle"}, 16'(tx), 16'd1);
      check1({tbl[i].name, "_busy_idle"}, 16'(busy), 16'd0);
      for (int j = 1; j < act_pops.size(); j++)
        check1({tbl[i].name, "_spacing"}, 16'(act_pops[j] - act_pops[j-1]), 16'(FRAME));
      q.delete();
      drive_fifo();
    end

    // After a long empty stretch, a new word must start a frame on the next edge.
    en = 1'b1;
    act_pops.delete();
    q.push_back(8'h81);
    drive_fifo();
    step();
    check1("late_word_pop", 16'(act_pops.size()), 16'd1);
    step();
    check1("late_word_start", 16'(tx), 16'd0);
    run(1100);
    check1("late_word_cnt", frame_cnt, 16'd6);

    // Random traffic: sporadic writes and enable toggling against the model.
    for (int c = 0; c < 20000; c++) begin
      if ((c % 500) == 0) en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 3 && q.size() < 4) begin
        q.push_back(8'($urandom));
        drive_fifo();
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
